// File: rtl/bridge_tx_ctrl_if.sv
// ----------------------------------------------------------------------------
// bridge_tx_ctrl_if
// Producer-side and bridge-side signal bundle of the clk1 transmit controller.
//   wr_en, wr_data        : producer write strobe and word
//   full, empty, count    : FIFO status (registered)
//   do_rdy, do_data       : level ready and word under offer toward the bridge
//   do_acpt_pulse         : one-cycle accept pulse returned by the bridge
//   ovf_err, timeout_err  : sticky error flags
//   err_clr               : clears both sticky flags
// Modports: slave = the controller, master = the producer/bridge side.
// ----------------------------------------------------------------------------
interface bridge_tx_ctrl_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          do_rdy;
  logic [DW-1:0] do_data;
  logic          do_acpt_pulse;
  logic          ovf_err;
  logic          timeout_err;
  logic          err_clr;

  modport slave (
    input  wr_en, wr_data, do_acpt_pulse, err_clr,
    output full, empty, count, do_rdy, do_data, ovf_err, timeout_err
  );

  modport master (
    output wr_en, wr_data, do_acpt_pulse, err_clr,
    input  full, empty, count, do_rdy, do_data, ovf_err, timeout_err
  );
endinterface

// File: rtl/bridge_tx_ctrl.sv
// ----------------------------------------------------------------------------
// bridge_tx_ctrl
// Transmit-side handshake controller in the source (clk1) domain of the async
// ready/accept bridge. Buffers producer words in a small FIFO, offers the head
// word as a level ready with stable data, retires it on the accept pulse and
// then holds ready low for a gap so the far-side synchronizers see each edge.
//
// Ports:
//   clk   : single clock (bridge clk1 domain)
//   rstn  : synchronous active-low reset
//   bus   : bridge_tx_ctrl_if.slave (write port, FIFO status, ready/data/accept,
//           sticky error flags and their clear)
//
// Optional feature: define BRIDGE_TX_TIMEOUT_EN to abort an offer that sees no
// accept within TIMEOUT cycles (word discarded, timeout_err set). Without it,
// SEND waits indefinitely and timeout_err stays 0.
// ----------------------------------------------------------------------------
module bridge_tx_ctrl #(
  parameter int unsigned DW         = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned GAP_CYCLES = 4
`ifdef BRIDGE_TX_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT    = 255
`endif
) (
  input logic             clk,
  input logic             rstn,
  bridge_tx_ctrl_if.slave bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
`ifdef BRIDGE_TX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [DW-1:0] mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q;
  logic          rdy_q, rdy_d;
  logic [DW-1:0] data_q, data_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          ovf_q, ovf_d;
  logic          tmo_err_q, tmo_err_d;
  logic          wr_ok, pop, tmo_evt;
`ifdef BRIDGE_TX_TIMEOUT_EN
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  // Next-state, offer control, FIFO bookkeeping and error flags
  always_comb begin
    state_d   = state_q;
    rdy_d     = rdy_q;
    data_d    = data_q;
    gap_d     = gap_q;
    pop       = 1'b0;
    tmo_evt   = 1'b0;
`ifdef BRIDGE_TX_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!empty_q) begin
          state_d = S_SEND;
          rdy_d   = 1'b1;
          data_d  = mem[rd_ptr_q];
`ifdef BRIDGE_TX_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      S_SEND: begin
        // An accept in the timeout cycle wins: normal retire, no error.
        if (bus.do_acpt_pulse) begin
          pop = 1'b1;
        end
`ifdef BRIDGE_TX_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          pop     = 1'b1;
          tmo_evt = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
        if (pop) begin
          rdy_d   = 1'b0;
          gap_d   = GW'(GAP_CYCLES - 1);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        rdy_d   = 1'b0;
      end
    endcase

    // full is registered, so a pop in the same cycle never makes room.
    wr_ok   = bus.wr_en && !full_q;
    count_d = count_q + CW'(wr_ok) - CW'(pop);

    // Set events take priority over the clear.
    ovf_d     = (bus.wr_en && full_q) ? 1'b1 : (bus.err_clr ? 1'b0 : ovf_q);
    tmo_err_d = tmo_evt ? 1'b1 : (bus.err_clr ? 1'b0 : tmo_err_q);
  end

  // State and control registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      rdy_q     <= 1'b0;
      data_q    <= '0;
      gap_q     <= '0;
      ovf_q     <= 1'b0;
      tmo_err_q <= 1'b0;
`ifdef BRIDGE_TX_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q   <= count_d;
      full_q    <= (count_d == CW'(DEPTH));
      empty_q   <= (count_d == '0);
      rdy_q     <= rdy_d;
      data_q    <= data_d;
      gap_q     <= gap_d;
      ovf_q     <= ovf_d;
      tmo_err_q <= tmo_err_d;
`ifdef BRIDGE_TX_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  // FIFO storage; contents need no reset
  always_ff @(posedge clk) begin
    if (rstn && wr_ok) begin
      mem[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.count       = count_q;
  assign bus.do_rdy      = rdy_q;
  assign bus.do_data     = data_q;
  assign bus.ovf_err     = ovf_q;
  assign bus.timeout_err = tmo_err_q;

endmodule

// File: tb/tb_bridge_tx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bridge_tx_ctrl
// Directed bench for bridge_tx_ctrl. A queue-and-timestamp model predicts the
// outputs each cycle; literal checks pin the key cases.
// ----------------------------------------------------------------------------
module tb_bridge_tx_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int          GAP   = 4;
`ifdef BRIDGE_TX_TIMEOUT_EN
  localparam int TMO    = 8;
  localparam bit TMO_ON = 1'b1;
`else
  localparam int TMO    = 0;
  localparam bit TMO_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  bridge_tx_ctrl_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  bridge_tx_ctrl #(
    .DW(DW),
    .DEPTH(DEPTH),
    .GAP_CYCLES(GAP)
`ifdef BRIDGE_TX_TIMEOUT_EN
    ,
    .TIMEOUT(TMO)
`endif
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of stored words; an offer may start once the queue is
  // visibly non-empty and GAP+1 edges have passed since the last retire.
  logic [7:0] mq[$];
  bit         m_rdy;
  logic [7:0] m_data;
  bit         m_ovf, m_tmo;
  int         m_start, m_earliest;
  int         edge_n = 0;

  always @(posedge clk) begin
    int  sz;
    bit  do_pop, ovf_evt, tmo_evt;
    edge_n++;
    if (!rstn) begin
      mq.delete();
      m_rdy = 1'b0; m_data = '0; m_ovf = 1'b0; m_tmo = 1'b0;
      m_start = 0; m_earliest = 0;
    end else begin
      sz = mq.size();
      do_pop = 1'b0; ovf_evt = 1'b0; tmo_evt = 1'b0;
      if (m_rdy) begin
        if (bus.do_acpt_pulse) do_pop = 1'b1;
        else if (TMO_ON && (edge_n - m_start == TMO)) begin
          do_pop = 1'b1; tmo_evt = 1'b1;
        end
        if (do_pop) begin
          m_rdy = 1'b0;
          m_earliest = edge_n + GAP + 1;
        end
      end else if (sz > 0 && edge_n >= m_earliest) begin
        m_rdy = 1'b1; m_data = mq[0]; m_start = edge_n;
      end
      if (do_pop) void'(mq.pop_front());
      if (bus.wr_en) begin
        if (sz == DEPTH) ovf_evt = 1'b1;
        else mq.push_back(bus.wr_data);
      end
      if (ovf_evt) m_ovf = 1'b1; else if (bus.err_clr) m_ovf = 1'b0;
      if (tmo_evt) m_tmo = 1'b1; else if (bus.err_clr) m_tmo = 1'b0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("do_rdy", bus.do_rdy, m_rdy);
      if (m_rdy) check("do_data", bus.do_data, m_data);
      check("count", bus.count, mq.size());
      check("empty", bus.empty, mq.size() == 0);
      check("full", bus.full, mq.size() == DEPTH);
      check("ovf_err", bus.ovf_err, m_ovf);
      check("timeout_err", bus.timeout_err, m_tmo);
    end
  end

  task automatic drive(input logic w, input logic [7:0] d, input logic a, input logic c);
    bus.wr_en = w; bus.wr_data = d; bus.do_acpt_pulse = a; bus.err_clr = c;
    @(negedge clk);
    bus.wr_en = 1'b0; bus.do_acpt_pulse = 1'b0; bus.err_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic wait_rdy(input int max, output int lows);
    lows = 0;
    while (bus.do_rdy !== 1'b1 && lows < max) begin
      lows++;
      idle(1);
    end
    check("wait_rdy", bus.do_rdy, 1'b1);
  endtask

  task automatic drain_one(input logic [7:0] exp);
    int lows;
    wait_rdy(20, lows);
    check("drain_data", bus.do_data, exp);
    idle(2);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_rdy_low", bus.do_rdy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lows;
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.do_acpt_pulse = 1'b0; bus.err_clr = 1'b0;
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    chk_en = 1'b1;
    check("rst_rdy", bus.do_rdy, 1'b0);
    check("rst_empty", bus.empty, 1'b1);
    check("rst_full", bus.full, 1'b0);
    check("rst_count", bus.count, 0);

    // Single transfer: write in cycle 0, offer from cycle 2, accept in cycle 10
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    check("t1_count", bus.count, 1);
    check("t1_rdy_early", bus.do_rdy, 1'b0);
    idle(1);
    check("t1_rdy", bus.do_rdy, 1'b1);
    check("t1_data", bus.do_data, 8'hA5);
    idle(8);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("t1_rdy_drop", bus.do_rdy, 1'b0);
    check("t1_empty", bus.empty, 1'b1);
    idle(6);

    // Back-to-back: order and exact low gap
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b1, 8'h02, 1'b0, 1'b0);
    drive(1'b1, 8'h03, 1'b0, 1'b0);
    wait_rdy(20, lows);
    check("t2_data1", bus.do_data, 8'h01);
    idle(4);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    wait_rdy(20, lows);
    check("t2_gap1", lows, 5);
    check("t2_data2", bus.do_data, 8'h02);
    idle(4);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    wait_rdy(20, lows);
    check("t2_gap2", lows, 5);
    check("t2_data3", bus.do_data, 8'h03);
    idle(4);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("t2_empty", bus.empty, 1'b1);
    idle(6);

    // Overflow, set-beats-clear, clear, drain of exactly four words
    drive(1'b1, 8'h10, 1'b0, 1'b0);
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 8'h12, 1'b0, 1'b0);
    drive(1'b1, 8'h13, 1'b0, 1'b0);
    check("t3_count4", bus.count, 4);
    check("t3_full", bus.full, 1'b1);
    drive(1'b1, 8'h14, 1'b0, 1'b0);
    check("t3_ovf", bus.ovf_err, 1'b1);
    check("t3_count_hold", bus.count, 4);
    drive(1'b1, 8'h99, 1'b0, 1'b1);
    check("t3_ovf_set_wins", bus.ovf_err, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("t3_ovf_clr", bus.ovf_err, 1'b0);
    drain_one(8'h10);
    drain_one(8'h11);
    drain_one(8'h12);
    drain_one(8'h13);
    idle(10);
    check("t3_no_fifth", bus.do_rdy, 1'b0);
    check("t3_empty", bus.empty, 1'b1);

    // Write coinciding with accept; spurious accept during the gap
    drive(1'b1, 8'h21, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    check("t4_count2", bus.count, 2);
    check("t4_rdy", bus.do_rdy, 1'b1);
    drive(1'b1, 8'h23, 1'b1, 1'b0);
    check("t4_count_same", bus.count, 2);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("t4_spurious", bus.count, 2);
    drain_one(8'h22);
    drain_one(8'h23);
    idle(6);

    // Reset mid-SEND with three words queued
    drive(1'b1, 8'h31, 1'b0, 1'b0);
    drive(1'b1, 8'h32, 1'b0, 1'b0);
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    check("t5_count3", bus.count, 3);
    check("t5_rdy", bus.do_rdy, 1'b1);
    rstn = 1'b0;
    idle(1);
    rstn = 1'b1;
    check("t5_rdy_low", bus.do_rdy, 1'b0);
    check("t5_count0", bus.count, 0);
    check("t5_empty", bus.empty, 1'b1);
    idle(12);
    check("t5_no_offer", bus.do_rdy, 1'b0);

`ifdef BRIDGE_TX_TIMEOUT_EN
    // Timeout abort, then an accept landing on the last allowed cycle
    drive(1'b1, 8'h61, 1'b0, 1'b0);
    drive(1'b1, 8'h62, 1'b0, 1'b0);
    check("t6_rdy", bus.do_rdy, 1'b1);
    idle(7);
    check("t6_rdy_held", bus.do_rdy, 1'b1);
    idle(1);
    check("t6_rdy_drop", bus.do_rdy, 1'b0);
    check("t6_tmo_err", bus.timeout_err, 1'b1);
    check("t6_count1", bus.count, 1);
    wait_rdy(20, lows);
    check("t6_gap", lows, 5);
    check("t6_data2", bus.do_data, 8'h62);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    idle(6);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("t6_acc_rdy", bus.do_rdy, 1'b0);
    check("t6_acc_no_err", bus.timeout_err, 1'b0);
    check("t6_acc_empty", bus.empty, 1'b1);
    idle(6);
`endif

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
